uart_snapshot_packer: RTL

- Sits between the board-level debug wiring and the UART transmitter.
- On each rising edge of the CPU step clock, it captures a wide debug snapshot (clks, pclow, memwrite, wreg, check word).
- It serialises the snapshot into a framed byte stream: sync byte, data bytes MSB-first, then a checksum byte. Bytes go out over a valid/ready interface into the TX byte FIFO/transmitter.
- Runs entirely in the 100 MHz domain. The step clock is treated as an asynchronous level and synchronised internally.

---
 rtl/uart_dbg_pkg.sv | 21 ++
 rtl/sync_edge.sv | 38 +++
 rtl/uart_snapshot_packer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_dbg_pkg.sv
// Shared types and helpers for the UART debug snapshot path.
//   state_e           : framer state encoding (IDLE, SYNC, DATA, SUM)
//   SYNC_BYTE_DEFAULT : default frame start marker
//   checksum_byte()   : two's-complement of a running byte sum, so that
//                       (sum of data bytes + checksum) mod 256 == 0
package uart_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        SUM  = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic logic [7:0] checksum_byte(input logic [7:0] sum);
        return (~sum) + 8'd1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a third flop used
// to produce a one-cycle pulse on each synchronised rising edge.
// Ports:
//   clk      : destination clock
//   rst_n    : asynchronous active-low reset (all flops cleared)
//   async_in : asynchronous input level
//   rise     : one-cycle pulse, high when s2 & ~s3
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/uart_snapshot_packer.sv
// Captures a wide debug snapshot on each rising edge of the CPU step clock
// and serialises it as: SYNC_BYTE, DATA_BYTES data bytes (MSB first), and a
// checksum byte, over a valid/ready byte interface.
// Ports:
//   CLK100MHZ : system clock
//   rst_n     : asynchronous active-low reset
//   trig      : step clock level (asynchronous); rising edge requests a frame
//   snap_in   : snapshot word, top byte is sent first
//   tx_data   : byte to transmitter (held while tx_valid & ~tx_ready)
//   tx_valid  : tx_data valid
//   tx_ready  : transmitter accepts the byte this cycle
//   busy      : a frame is in progress
//   overrun   : sticky, a request arrived while one was already pending
//   frame_cnt : number of completed frames, wraps
module uart_snapshot_packer
    import uart_dbg_pkg::*;
#(
    parameter int         DATA_BYTES = 8,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                    CLK100MHZ,
    input  logic                    rst_n,
    input  logic                    trig,
    input  logic [8*DATA_BYTES-1:0] snap_in,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic                    overrun,
    output logic [7:0]              frame_cnt
);

    localparam int SNAP_W = 8 * DATA_BYTES;
    localparam int IDX_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

    // Byte i of the snapshot, counting from the most significant byte.
    function automatic logic [7:0] byte_at(input logic [SNAP_W-1:0] w,
                                           input logic [IDX_W-1:0]  i);
        logic [SNAP_W-1:0] sh;
        sh = w << (8 * i);
        return sh[SNAP_W-1 -: 8];
    endfunction

    logic trig_rise;

    sync_edge u_trig_sync (
        .clk      (CLK100MHZ),
        .rst_n    (rst_n),
        .async_in (trig),
        .rise     (trig_rise)
    );

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [SNAP_W-1:0] shadow_q, shadow_d;
    logic [SNAP_W-1:0] pend_buf_q, pend_buf_d;
    logic              pending_q, pending_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic       xfer;
    logic       consume_now;
    logic [7:0] next_sum;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        shadow_d    = shadow_q;
        pend_buf_d  = pend_buf_q;
        pending_d   = pending_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;

        xfer     = tx_valid_q & tx_ready;
        next_sum = sum_q + tx_data_q;
        // An edge landing on the final checksum transfer with nothing pending
        // starts the next frame directly instead of going through pend_buf.
        consume_now = (state_q == SUM) && xfer && !pending_q && trig_rise;

        // Outputs are registered, so each branch loads the byte for the
        // state being entered.
        unique case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    shadow_d   = snap_in;
                    sum_d      = 8'd0;
                    idx_d      = '0;
                    state_d    = SYNC;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                end
            end
            SYNC: begin
                if (xfer) begin
                    state_d   = DATA;
                    idx_d     = '0;
                    tx_data_d = byte_at(shadow_q, '0);
                end
            end
            DATA: begin
                if (xfer) begin
                    sum_d = next_sum;
                    if (idx_q == LAST_IDX) begin
                        state_d   = SUM;
                        tx_data_d = checksum_byte(next_sum);
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        tx_data_d = byte_at(shadow_q, idx_q + 1'b1);
                    end
                end
            end
            SUM: begin
                if (xfer) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (pending_q || trig_rise) begin
                        shadow_d   = pending_q ? pend_buf_q : snap_in;
                        pending_d  = 1'b0;
                        sum_d      = 8'd0;
                        idx_d      = '0;
                        state_d    = SYNC;
                        tx_data_d  = SYNC_BYTE;
                    end else begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Requests while a frame is running: one slot of buffering, then drop.
        if (trig_rise && (state_q != IDLE) && !consume_now) begin
            if (!pending_q) begin
                pend_buf_d = snap_in;
                pending_d  = 1'b1;
            end else begin
                overrun_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sum_q       <= 8'd0;
            shadow_q    <= '0;
            pend_buf_q  <= '0;
            pending_q   <= 1'b0;
            tx_data_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            shadow_q    <= shadow_d;
            pend_buf_q  <= pend_buf_d;
            pending_q   <= pending_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule
